// File: rtl/mem_arb_pkg.sv
// Shared types and field layout for the two-requester refill arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR
  } state_e;

  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;

  // Byte-address field layout: [11:4] line, [3:2] word in line, [1:0] byte.
  localparam int WORD_LSB = 2;
  localparam int WORD_MSB = 3;
  localparam int LINE_LSB = 4;
  localparam int LINE_MSB = 11;
  localparam int LINE_W   = LINE_MSB - LINE_LSB + 1;

  // Word-aligned byte address of word 'word' within line 'line'.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        word);
    return {line, word, 2'b00};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
// Latency: grant is combinational from req; pointer updates on the accepting edge.
// Backpressure: pointer only moves when the consumer accepts the grant.
// Ports: req[1:0] requests, accept = grant taken this cycle, gnt[1:0] one-hot grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // last_q = index of the requester granted most recently; 1 after reset so
  // requester 0 wins the first contention.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = req;
    last_d = last_q;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
    if (accept) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_refill_arb.sv
// Shares one memory port between I-cache (req 0) and D-cache (req 1): 4-word line refill or 1-word write-through.
// Latency: first access 1 cycle after grant; fill k at (k+1)(MEM_LAT+1)+1; write done 1 cycle after grant.
// Backpressure: requests are held until done; one transaction at a time, one outstanding memory read.
// Ports: req_* per-requester request side, fill_*/done owner return side, MEM_*/mem_en/MEMW memory port.
module mem_refill_arb
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic [1:0]        done,
  output logic              busy,
  output logic              MEMW,
  output logic              mem_en,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DI,
  input  logic [DATA_W-1:0] MEM_DOUT
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [1:0]          word_q, word_d;
  logic [2:0]          lat_q, lat_d;
  logic [1:0]          fill_valid_q, fill_valid_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0]   fill_data_q, fill_data_d;
  logic [1:0]          done_q, done_d;
  logic                mem_en_q, mem_en_d;
  logic                memw_q, memw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_di_q, mem_di_d;

  logic [1:0]          gnt;
  logic                accept;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;
  logic [1:0]          owner_oh;
  logic [1:0]          next_word;
  logic                unused_addr_bits;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req_valid),
    .accept (accept),
    .gnt    (gnt)
  );

  assign sel_addr  = gnt[1] ? req_addr1  : req_addr0;
  assign sel_wdata = gnt[1] ? req_wdata1 : req_wdata0;
  assign sel_write = gnt[1] ? req_write[1] : req_write[0];
  assign owner_oh  = owner_q ? 2'b10 : 2'b01;
  assign next_word = word_q + 2'd1;
  assign unused_addr_bits = ^{req_addr0[1:0], req_addr1[1:0]};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    line_d       = line_q;
    word_d       = word_q;
    lat_d        = lat_q;
    fill_valid_d = 2'b00;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    done_d       = 2'b00;
    mem_en_d     = 1'b0;
    memw_d       = 1'b1;
    mem_addr_d   = mem_addr_q;
    mem_di_d     = mem_di_q;
    accept       = 1'b0;

    // Memory-port outputs are registered, so each access is set up on the
    // edge that enters RD_ISSUE/WR and is visible throughout that state.
    unique case (state_q)
      S_IDLE: begin
        // While the previous owner's done is still showing it has not yet
        // dropped req_valid; hold off one cycle so it cannot be re-granted.
        if ((gnt != 2'b00) && (done_q == 2'b00)) begin
          accept   = 1'b1;
          owner_d  = gnt[1];
          line_d   = sel_addr[LINE_MSB:LINE_LSB];
          word_d   = 2'd0;
          mem_en_d = 1'b1;
          if (sel_write) begin
            state_d    = S_WR;
            memw_d     = 1'b0;
            mem_addr_d = {sel_addr[ADDR_W-1:WORD_LSB], 2'b00};
            mem_di_d   = sel_wdata;
            done_d     = gnt;
          end else begin
            state_d    = S_RD_ISSUE;
            mem_addr_d = word_addr(sel_addr[LINE_MSB:LINE_LSB], 2'd0);
          end
        end
      end

      S_RD_ISSUE: begin
        lat_d   = 3'(MEM_LAT);
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (lat_q == 3'd1) begin
          // MEM_DOUT is valid this cycle; mem_addr_q still holds its address.
          fill_valid_d = owner_oh;
          fill_addr_d  = mem_addr_q;
          fill_data_d  = MEM_DOUT;
          if (word_q == 2'd3) begin
            done_d  = owner_oh;
            word_d  = 2'd0;
            state_d = S_IDLE;
          end else begin
            word_d     = next_word;
            state_d    = S_RD_ISSUE;
            mem_en_d   = 1'b1;
            mem_addr_d = word_addr(line_q, next_word);
          end
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end

      S_WR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      line_q       <= '0;
      word_q       <= 2'd0;
      lat_q        <= 3'd0;
      fill_valid_q <= 2'b00;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      done_q       <= 2'b00;
      mem_en_q     <= 1'b0;
      memw_q       <= 1'b1;
      mem_addr_q   <= '0;
      mem_di_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      line_q       <= line_d;
      word_q       <= word_d;
      lat_q        <= lat_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      done_q       <= done_d;
      mem_en_q     <= mem_en_d;
      memw_q       <= memw_d;
      mem_addr_q   <= mem_addr_d;
      mem_di_q     <= mem_di_d;
    end
  end

  assign fill_valid = fill_valid_q;
  assign fill_addr  = fill_addr_q;
  assign fill_data  = fill_data_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);
  assign mem_en     = mem_en_q;
  assign MEMW       = memw_q;
  assign MEM_ADDR   = mem_addr_q;
  assign MEM_DI     = mem_di_q;

endmodule

// File: tb/tb_mem_refill_arb.sv
// Bench for mem_refill_arb: three instances (MEM_LAT 2, 1, 7) each with a pipelined memory model.
// Expected memory accesses, fills and done pulses are queued with their cycle when stimulus is driven.
// Requesters hold req_valid until they see done, then drop it on that edge.
module tb_mem_refill_arb;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [1:0]  who;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk;
  logic        rstn;
  logic [1:0]  req_write;
  logic [11:0] req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;

  logic [1:0]  rv         [3];
  logic [1:0]  fill_valid_a [3];
  logic [11:0] fill_addr_a  [3];
  logic [31:0] fill_data_a  [3];
  logic [1:0]  done_a     [3];
  logic        busy_a     [3];
  logic        memw_a     [3];
  logic        mem_en_a   [3];
  logic [11:0] mem_addr_a [3];
  logic [31:0] mem_di_a   [3];
  logic [31:0] mem_dout_a [3];

  int cyc = 0;
  int cur = 0;
  bit mon_en = 0;
  int checks = 0;
  int errors = 0;

  ev_t acc_q[$];
  ev_t fill_q[$];
  ev_t done_q[$];
  ev_t e_acc, e_fill, e_done;

  function automatic logic [31:0] dfn(input logic [11:0] a);
    return {a, 8'h5A, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 7;
    logic [12:0] pipe [8];

    mem_refill_arb #(.MEM_LAT(LAT)) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (rv[g]),
      .req_write  (req_write),
      .req_addr0  (req_addr0),
      .req_addr1  (req_addr1),
      .req_wdata0 (req_wdata0),
      .req_wdata1 (req_wdata1),
      .fill_valid (fill_valid_a[g]),
      .fill_addr  (fill_addr_a[g]),
      .fill_data  (fill_data_a[g]),
      .done       (done_a[g]),
      .busy       (busy_a[g]),
      .MEMW       (memw_a[g]),
      .mem_en     (mem_en_a[g]),
      .MEM_ADDR   (mem_addr_a[g]),
      .MEM_DI     (mem_di_a[g]),
      .MEM_DOUT   (mem_dout_a[g])
    );

    // Read issued in cycle c shows up on MEM_DOUT during cycle c+LAT only.
    always @(posedge clk) begin
      pipe[0] <= {mem_en_a[g] & memw_a[g], mem_addr_a[g]};
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_dout_a[g] = (pipe[LAT-1][12] === 1'b1) ? dfn(pipe[LAT-1][11:0]) : 32'hDEAD_DEAD;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_en_a[cur]) begin
        if (acc_q.size() == 0) chk("acc_unexpected", 32'd1, 32'd0);
        else begin
          e_acc = acc_q.pop_front();
          chk("acc_cyc", cyc, e_acc.cyc);
          chk("acc_memw", {31'd0, memw_a[cur]}, {31'd0, ~e_acc.wr});
          chk("acc_addr", {20'd0, mem_addr_a[cur]}, {20'd0, e_acc.addr});
          if (e_acc.wr) chk("acc_di", mem_di_a[cur], e_acc.data);
        end
      end
      if (fill_valid_a[cur] != 2'b00) begin
        if (fill_q.size() == 0) chk("fill_unexpected", 32'd1, 32'd0);
        else begin
          e_fill = fill_q.pop_front();
          chk("fill_cyc", cyc, e_fill.cyc);
          chk("fill_valid", {30'd0, fill_valid_a[cur]}, {30'd0, e_fill.who});
          chk("fill_addr", {20'd0, fill_addr_a[cur]}, {20'd0, e_fill.addr});
          chk("fill_data", fill_data_a[cur], e_fill.data);
        end
      end
      if (done_a[cur] != 2'b00) begin
        if (done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          e_done = done_q.pop_front();
          chk("done_cyc", cyc, e_done.cyc);
          chk("done_who", {30'd0, done_a[cur]}, {30'd0, e_done.who});
        end
      end
    end
  end

  function automatic logic [1:0] oh(input int who);
    return (who == 1) ? 2'b10 : 2'b01;
  endfunction

  // s = cycle of the first memory access (grant cycle + 1).
  task automatic push_refill(input int who, input logic [11:0] a, input int s, input int lat);
    ev_t e;
    logic [11:0] wa;
    for (int k = 0; k < 4; k++) begin
      wa = {a[11:4], 4'b0000} | 12'(k * 4);
      e = '{cyc: s + k * (lat + 1), wr: 1'b0, who: oh(who), addr: wa, data: 32'd0};
      acc_q.push_back(e);
      e = '{cyc: s + (k + 1) * (lat + 1), wr: 1'b0, who: oh(who), addr: wa, data: dfn(wa)};
      fill_q.push_back(e);
    end
    e = '{cyc: s + 4 * (lat + 1), wr: 1'b0, who: oh(who), addr: 12'd0, data: 32'd0};
    done_q.push_back(e);
  endtask

  task automatic push_write(input int who, input logic [11:0] a, input logic [31:0] wd, input int s);
    ev_t e;
    e = '{cyc: s, wr: 1'b1, who: oh(who), addr: {a[11:2], 2'b00}, data: wd};
    acc_q.push_back(e);
    e = '{cyc: s, wr: 1'b1, who: oh(who), addr: 12'd0, data: 32'd0};
    done_q.push_back(e);
  endtask

  task automatic start_req(input int who, input bit wr, input logic [11:0] a, input logic [31:0] wd);
    req_write[who] = wr;
    if (who == 0) begin
      req_addr0  = a;
      req_wdata0 = wd;
    end else begin
      req_addr1  = a;
      req_wdata1 = wd;
    end
    rv[cur][who] = 1'b1;
  endtask

  // Returns at #1 after the edge that follows the done cycle, with req_valid dropped.
  task automatic wait_done(input int who);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (done_a[cur][who] === 1'b1) break;
      if (n > 200) begin
        chk("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    rv[cur][who] = 1'b0;
  endtask

  int t0;
  int n_ev;

  initial begin
    rstn = 1'b0;
    req_write = 2'b00;
    req_addr0 = '0;
    req_addr1 = '0;
    req_wdata0 = '0;
    req_wdata1 = '0;
    for (int i = 0; i < 3; i++) rv[i] = 2'b00;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a refill.
    t0 = cyc;
    start_req(0, 1'b0, 12'h3A4, 32'd0);
    while (cyc < t0 + 6) begin
      @(posedge clk);
      #1;
    end
    #2;
    chk("busy_mid_refill", {31'd0, busy_a[0]}, 32'd1);
    rstn = 1'b0;
    rv[0] = 2'b00;
    #1;
    chk("rst_fill_valid", {30'd0, fill_valid_a[0]}, 32'd0);
    chk("rst_done", {30'd0, done_a[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy_a[0]}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en_a[0]}, 32'd0);
    chk("rst_memw", {31'd0, memw_a[0]}, 32'd1);
    chk("rst_mem_addr", {20'd0, mem_addr_a[0]}, 32'd0);
    chk("rst_mem_di", mem_di_a[0], 32'd0);
    chk("rst_fill_addr", {20'd0, fill_addr_a[0]}, 32'd0);
    chk("rst_fill_data", fill_data_a[0], 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    n_ev = 0;
    repeat (20) begin
      @(negedge clk);
      if (fill_valid_a[0] != 2'b00 || done_a[0] != 2'b00) n_ev++;
    end
    chk("post_rst_events", n_ev, 32'd0);
    @(posedge clk);
    #1;

    mon_en = 1'b1;

    // Contention right after reset: req0 refill wins, req1 write follows.
    t0 = cyc;
    push_refill(0, 12'h124, t0 + 1, 2);
    push_write(1, 12'h358, 32'h1234_5678, t0 + 15);
    start_req(0, 1'b0, 12'h124, 32'd0);
    start_req(1, 1'b1, 12'h358, 32'h1234_5678);
    wait_done(0);
    wait_done(1);

    // Second contention: req1 was granted last, so req0 wins.
    t0 = cyc;
    push_write(0, 12'h010, 32'hAAAA_0001, t0 + 1);
    push_write(1, 12'h020, 32'hBBBB_0002, t0 + 3);
    start_req(0, 1'b1, 12'h010, 32'hAAAA_0001);
    start_req(1, 1'b1, 12'h020, 32'hBBBB_0002);
    wait_done(0);
    wait_done(1);

    // Single refill, req0, MEM_LAT=2.
    t0 = cyc;
    push_refill(0, 12'h3A4, t0 + 1, 2);
    start_req(0, 1'b0, 12'h3A4, 32'd0);
    wait_done(0);

    // Write-through, req1.
    t0 = cyc;
    push_write(1, 12'h0F6, 32'hDEAD_BEEF, t0 + 1);
    start_req(1, 1'b1, 12'h0F6, 32'hDEAD_BEEF);
    wait_done(1);

    // Back-to-back writes from req1: done every 2 cycles.
    for (int i = 0; i < 3; i++) begin
      t0 = cyc;
      push_write(1, 12'(12'h800 + i * 4 + 1), 32'hC0DE_0000 + i, t0 + 1);
      start_req(1, 1'b1, 12'(12'h800 + i * 4 + 1), 32'hC0DE_0000 + i);
      wait_done(1);
    end

    // MEM_LAT=1 instance: done at cycle 9.
    repeat (2) @(posedge clk);
    #1 cur = 1;
    t0 = cyc;
    push_refill(0, 12'h5C8, t0 + 1, 1);
    start_req(0, 1'b0, 12'h5C8, 32'd0);
    wait_done(0);

    // MEM_LAT=7 instance: done at cycle 33.
    repeat (2) @(posedge clk);
    #1 cur = 2;
    t0 = cyc;
    push_refill(1, 12'hAB0, t0 + 1, 7);
    start_req(1, 1'b0, 12'hAB0, 32'd0);
    wait_done(1);

    repeat (5) @(negedge clk);
    chk("acc_left", acc_q.size(), 32'd0);
    chk("fill_left", fill_q.size(), 32'd0);
    chk("done_left", done_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
